alu_multicycle_exec: RTL

- Execute-stage ALU that consumes the 4-bit Operation code produced by ALUController and performs the operation on two operands.
- Most operations complete in one cycle. Shifts run on an iterative shifter, so latency depends on the shift amount.
- Valid/ready handshakes on both input and output let the pipeline stall cleanly around multi-cycle shifts.

---
 rtl/alu_op_pkg.sv | 29 ++
 rtl/alu_shift_unit.sv | 68 ++++++
 rtl/alu_multicycle_exec.sv | 131 +++++++++++++
 3 files changed

// File: rtl/alu_op_pkg.sv
// Operation codes shared between ALUController and the execute-stage ALU.
package alu_op_pkg;

    localparam int unsigned ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        OpAnd   = 4'b0000,
        OpOr    = 4'b0001,
        OpAdd   = 4'b0010,
        OpXor   = 4'b0011,
        OpSll   = 4'b0100,
        OpSrl   = 4'b0101,
        OpSub   = 4'b0110,
        OpSra   = 4'b0111,
        OpEq    = 4'b1000,
        OpNe    = 4'b1001,
        OpPassB = 4'b1010,
        OpRsvd  = 4'b1011,
        OpLt    = 4'b1100,
        OpGe    = 4'b1101,
        OpLtu   = 4'b1110,
        OpGeu   = 4'b1111
    } alu_op_e;

    function automatic logic is_shift(input alu_op_e op);
        return (op == OpSll) || (op == OpSrl) || (op == OpSra);
    endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Iterative shifter: moves at most SHIFT_STEP bit positions per cycle until the count runs out.
module alu_shift_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic                          dir,
    input  logic                          arith,
    input  logic [DATA_WIDTH-1:0]         a,
    input  logic [$clog2(DATA_WIDTH)-1:0] shamt,
    output logic                          busy,
    output logic [DATA_WIDTH-1:0]         value
);

    localparam int unsigned SHW = $clog2(DATA_WIDTH);
    localparam int unsigned AW  = SHW + 1;
    localparam logic [AW-1:0] STEP_L = AW'(SHIFT_STEP);

    logic [DATA_WIDTH-1:0] value_q, value_d;
    logic [SHW-1:0]        rem_q, rem_d;
    logic                  dir_q, dir_d;
    logic                  arith_q, arith_d;
    logic [AW-1:0]         amt;

    always_comb begin
        value_d = value_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        arith_d = arith_q;
        amt     = (AW'(rem_q) < STEP_L) ? AW'(rem_q) : STEP_L;
        if (load) begin
            value_d = a;
            rem_d   = shamt;
            dir_d   = dir;
            arith_d = arith;
        end else if (rem_q != '0) begin
            if (!dir_q) begin
                value_d = value_q << amt;
            end else if (arith_q) begin
                value_d = $signed(value_q) >>> amt;
            end else begin
                value_d = value_q >> amt;
            end
            rem_d = rem_q - amt[SHW-1:0];
        end
    end

    // Both outputs look one step ahead so the owner can leave SHIFT on the final step's edge.
    assign busy  = (rem_d != '0);
    assign value = value_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_q <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            value_q <= value_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            arith_q <= arith_d;
        end
    end

endmodule

// File: rtl/alu_multicycle_exec.sv
// Execute-stage ALU with valid/ready handshakes; shifts run on an iterative shifter.
module alu_multicycle_exec
    import alu_op_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ALU_OP_W-1:0]   op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  branch_taken
);

    localparam int unsigned SHW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  branch_q, branch_d;
    logic [DATA_WIDTH-1:0] alu_value, shift_value;
    logic                  cmp, shift_load, shift_busy;
    alu_op_e               op_e;
    logic [SHW-1:0]        shamt;

    assign op_e  = alu_op_e'(op);
    assign shamt = b[SHW-1:0];

    always_comb begin
        cmp = 1'b0;
        case (op_e)
            OpEq:    cmp = (a == b);
            OpNe:    cmp = (a != b);
            OpLt:    cmp = ($signed(a) < $signed(b));
            OpGe:    cmp = ($signed(a) >= $signed(b));
            OpLtu:   cmp = (a < b);
            OpGeu:   cmp = (a >= b);
            default: cmp = 1'b0;
        endcase
    end

    always_comb begin
        alu_value = '0;
        case (op_e)
            OpAnd:   alu_value = a & b;
            OpOr:    alu_value = a | b;
            OpAdd:   alu_value = a + b;
            OpXor:   alu_value = a ^ b;
            OpSub:   alu_value = a - b;
            // Shifts only take this path when shamt is zero.
            OpSll, OpSrl, OpSra: alu_value = a;
            OpPassB: alu_value = b;
            OpEq, OpNe, OpLt, OpGe, OpLtu, OpGeu: alu_value = DATA_WIDTH'(cmp);
            default: alu_value = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        branch_d   = branch_q;
        shift_load = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (is_shift(op_e) && (shamt != '0)) begin
                        shift_load = 1'b1;
                        state_d    = StShift;
                    end else begin
                        result_d = alu_value;
                        branch_d = cmp;
                        state_d  = StDone;
                    end
                end
            end
            StShift: begin
                if (!shift_busy) begin
                    result_d = shift_value;
                    branch_d = 1'b0;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            result_q <= '0;
            branch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            branch_q <= branch_d;
        end
    end

    alu_shift_unit #(
        .DATA_WIDTH(DATA_WIDTH),
        .SHIFT_STEP(SHIFT_STEP)
    ) u_shift (
        .clk   (clk),
        .reset (reset),
        .load  (shift_load),
        .dir   (op_e != OpSll),
        .arith (op_e == OpSra),
        .a     (a),
        .shamt (shamt),
        .busy  (shift_busy),
        .value (shift_value)
    );

    assign in_ready     = (state_q == StIdle);
    assign out_valid    = (state_q == StDone);
    assign result       = result_q;
    assign branch_taken = branch_q;

endmodule
